// File: rtl/mux_r_out.sv
// Output-port mux: latches register-file writes into eight 8-bit ports
// and mirrors each accepted write to a peripheral over a 4-phase handshake.
//
// Parameters:
//   SEL_WR      SELEC code that requests a port write
//   TIMEOUT_CYC SEND cycles without DATO_ACK before the transfer is abandoned
// Ports:
//   CLK, RST    clock, asynchronous active-high reset
//   RX          destination port index
//   RX_DATO     write data
//   SELEC       operation select
//   WR_EN       write strobe
//   PUERTOS     eight latched ports, port n = PUERTOS[8n+7:8n]
//   DATO_OUT    handshake data
//   PUERTO_ADDR handshake port index
//   DATO_VALID  handshake request (high only in SEND)
//   DATO_ACK    handshake acknowledge from peripheral
//   BUSY        transfer in progress
//   OVERRUN     sticky: a write arrived while busy and was dropped
//   TIMEOUT     sticky: a transfer was abandoned for lack of DATO_ACK
// Build option:
//   MUX_R_OUT_TIMEOUT_EN  adds the SEND timeout counter; otherwise TIMEOUT=0
//   and SEND waits for DATO_ACK indefinitely.

module mux_r_out #(
    parameter logic [2:0] SEL_WR      = 3'b100,
    parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  RX,
    input  logic [7:0]  RX_DATO,
    input  logic [2:0]  SELEC,
    input  logic        WR_EN,
    output logic [63:0] PUERTOS,
    output logic [7:0]  DATO_OUT,
    output logic [2:0]  PUERTO_ADDR,
    output logic        DATO_VALID,
    input  logic        DATO_ACK,
    output logic        BUSY,
    output logic        OVERRUN,
    output logic        TIMEOUT
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state;
    logic   wr_req;

    assign wr_req = WR_EN && (SELEC == SEL_WR);

`ifdef MUX_R_OUT_TIMEOUT_EN
    logic [7:0] cnt;
    logic       cnt_done;

    // True on the edge that closes the TIMEOUT_CYC-th SEND cycle.
    assign cnt_done = (cnt + 8'd1) == TIMEOUT_CYC;
`else
    assign TIMEOUT = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            PUERTOS     <= 64'h0;
            DATO_OUT    <= 8'h00;
            PUERTO_ADDR <= 3'b000;
            DATO_VALID  <= 1'b0;
            BUSY        <= 1'b0;
            OVERRUN     <= 1'b0;
`ifdef MUX_R_OUT_TIMEOUT_EN
            TIMEOUT     <= 1'b0;
            cnt         <= 8'h00;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr_req) begin
                        PUERTOS[{RX, 3'b000} +: 8] <= RX_DATO;
                        DATO_OUT    <= RX_DATO;
                        PUERTO_ADDR <= RX;
                        DATO_VALID  <= 1'b1;
                        BUSY        <= 1'b1;
                        state       <= SEND;
`ifdef MUX_R_OUT_TIMEOUT_EN
                        cnt         <= 8'h00;
`endif
                    end
                end
                SEND: begin
                    if (wr_req) OVERRUN <= 1'b1;
                    if (DATO_ACK) begin
                        DATO_VALID <= 1'b0;
                        state      <= RELEASE;
                    end
`ifdef MUX_R_OUT_TIMEOUT_EN
                    else if (cnt_done) begin
                        // Port data stays; only the handshake is abandoned.
                        DATO_VALID <= 1'b0;
                        BUSY       <= 1'b0;
                        TIMEOUT    <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
`endif
                end
                RELEASE: begin
                    // Still RELEASE at this edge, so a write here is dropped.
                    if (wr_req) OVERRUN <= 1'b1;
                    if (!DATO_ACK) begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    DATO_VALID <= 1'b0;
                    BUSY       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
